cv32e40p_ft_perm_fault_mgr: RTL and testbench

Downstream consumer of the per-replica error flags produced by the triplicated EX-stage units (ALU/MULT).
- Accumulates per-replica error history in leaky counters and declares a replica permanently faulty once its counter crosses a threshold.
- Reconfigures the 3-of-4 replica selection muxes to swap in the spare replica, and flags degraded operation once no spare remains.
- Emits one-cycle performance-counter events.

---
 rtl/cv32e40p_ft_perm_fault_mgr.sv | 156 +++++++++++++++
 tb/tb_cv32e40p_ft_perm_fault_mgr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ft_perm_fault_mgr.sv
// Permanent-fault manager for the triplicated EX units: leaky per-replica error
// counters, sticky fault flags, spare swap-in via the 3-of-4 selection muxes.
module cv32e40p_ft_perm_fault_mgr #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned THRESHOLD = 100,
    parameter int unsigned INC       = 1,
    parameter int unsigned DEC       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] enable_i,
    input  logic [3:0] err_detected_i,
    input  logic       pipe_idle_i,
    input  logic       clear_i,
    output logic [2:0] sel_mux_o,
    output logic [3:0] faulty_o,
    output logic [3:0] perf_event_o,
    output logic       reconfig_busy_o,
    output logic       degraded_o
);

    localparam int unsigned NREP = 4;
    localparam logic [CNT_W:0]   CNT_MAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0]   INC_W   = (CNT_W+1)'(INC);
    localparam logic [CNT_W-1:0] INC_V   = CNT_W'(INC);
    localparam logic [CNT_W-1:0] DEC_V   = CNT_W'(DEC);
    localparam logic [CNT_W-1:0] THR_V   = CNT_W'(THRESHOLD);

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        SWAP_PEND = 2'd1,
        SPARED    = 2'd2,
        DEGRADED  = 2'd3
    } state_e;

    state_e           state_q, state_n;
    logic [CNT_W-1:0] cnt_q [NREP];
    logic [CNT_W-1:0] cnt_n [NREP];
    logic [3:0]       in_use;
    logic [3:0]       over_thr;
    logic [3:0]       new_fault;
    logic [1:0]       swap_idx_q, swap_idx_n;
    logic             pend_deg_q, pend_deg_n;
    logic [2:0]       sel_n;
    logic [2:0]       low_mask;
    logic [1:0]       low_idx;
    logic             others;

    // The spare only accumulates history while it is actually voting.
    assign in_use = {state_q == SPARED, sel_mux_o};

    // Leaky counters: saturating increment on error, floor-at-zero decrement on clean.
    always_comb begin
        for (int i = 0; i < NREP; i++) begin
            cnt_n[i]    = cnt_q[i];
            over_thr[i] = cnt_q[i] > THR_V;
            if (enable_i[i] && in_use[i] && !faulty_o[i]) begin
                if (err_detected_i[i]) begin
                    cnt_n[i] = (({1'b0, cnt_q[i]} + INC_W) > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                                                     : cnt_q[i] + INC_V;
                end else begin
                    cnt_n[i] = (cnt_q[i] > DEC_V) ? cnt_q[i] - DEC_V : '0;
                end
            end
        end
    end

    assign new_fault = over_thr & ~faulty_o;

    // Reconfiguration FSM reacts to the registered fault pulse.
    always_comb begin
        state_n    = state_q;
        sel_n      = sel_mux_o;
        swap_idx_n = swap_idx_q;
        pend_deg_n = pend_deg_q;
        low_mask   = perf_event_o[2:0] & (~perf_event_o[2:0] + 3'd1);
        low_idx    = low_mask[0] ? 2'd0 : (low_mask[1] ? 2'd1 : 2'd2);
        others     = |(perf_event_o & ~{1'b0, low_mask});

        case (state_q)
            NORMAL: begin
                if (|perf_event_o[2:0]) begin
                    if (faulty_o[3] && !perf_event_o[3]) begin
                        // Spare already lost earlier: nothing left to swap in.
                        state_n = DEGRADED;
                    end else begin
                        swap_idx_n = low_idx;
                        pend_deg_n = others;
                        if (pipe_idle_i) begin
                            sel_n      = sel_mux_o & ~low_mask;
                            state_n    = others ? DEGRADED : SPARED;
                            pend_deg_n = 1'b0;
                        end else begin
                            state_n = SWAP_PEND;
                        end
                    end
                end
            end
            SWAP_PEND: begin
                pend_deg_n = pend_deg_q | (|perf_event_o);
                if (pipe_idle_i) begin
                    sel_n      = sel_mux_o & ~(3'b001 << swap_idx_q);
                    state_n    = (pend_deg_q || (|perf_event_o)) ? DEGRADED : SPARED;
                    pend_deg_n = 1'b0;
                end
            end
            SPARED: begin
                if (|perf_event_o) begin
                    state_n = DEGRADED;
                end
            end
            DEGRADED: begin
                state_n = DEGRADED;
            end
            default: begin
                state_n = NORMAL;
            end
        endcase
    end

    // State, counters and registered outputs; clear_i overrides every update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= NORMAL;
            cnt_q           <= '{default: '0};
            swap_idx_q      <= 2'd0;
            pend_deg_q      <= 1'b0;
            sel_mux_o       <= 3'b111;
            faulty_o        <= 4'b0000;
            perf_event_o    <= 4'b0000;
            reconfig_busy_o <= 1'b0;
            degraded_o      <= 1'b0;
        end else if (clear_i) begin
            state_q         <= NORMAL;
            cnt_q           <= '{default: '0};
            swap_idx_q      <= 2'd0;
            pend_deg_q      <= 1'b0;
            sel_mux_o       <= 3'b111;
            faulty_o        <= 4'b0000;
            perf_event_o    <= 4'b0000;
            reconfig_busy_o <= 1'b0;
            degraded_o      <= 1'b0;
        end else begin
            state_q         <= state_n;
            cnt_q           <= cnt_n;
            swap_idx_q      <= swap_idx_n;
            pend_deg_q      <= pend_deg_n;
            sel_mux_o       <= sel_n;
            faulty_o        <= faulty_o | new_fault;
            perf_event_o    <= new_fault;
            reconfig_busy_o <= (state_n == SWAP_PEND);
            degraded_o      <= (state_n == DEGRADED);
        end
    end

endmodule

// File: tb/tb_cv32e40p_ft_perm_fault_mgr.sv
// Directed bench for the permanent-fault manager: expected output snapshots are
// queued before each step and popped against the DUT after the step completes.
module tb_cv32e40p_ft_perm_fault_mgr;

    logic       clk;
    logic       rst_n;
    logic [3:0] enable_i;
    logic [3:0] err_detected_i;
    logic       pipe_idle_i;
    logic       clear_i;
    logic [2:0] sel_mux_o;
    logic [3:0] faulty_o;
    logic [3:0] perf_event_o;
    logic       reconfig_busy_o;
    logic       degraded_o;

    typedef struct {
        string      tag;
        logic [2:0] sel;
        logic [3:0] flt;
        logic [3:0] perf;
        logic       busy;
        logic       deg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    cv32e40p_ft_perm_fault_mgr dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .err_detected_i (err_detected_i),
        .pipe_idle_i    (pipe_idle_i),
        .clear_i        (clear_i),
        .sel_mux_o      (sel_mux_o),
        .faulty_o       (faulty_o),
        .perf_event_o   (perf_event_o),
        .reconfig_busy_o(reconfig_busy_o),
        .degraded_o     (degraded_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s observed %b expected %b", tag, field, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] sel, input logic [3:0] flt,
                            input logic [3:0] perf, input logic busy, input logic deg);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.flt  = flt;
        e.perf = perf;
        e.busy = busy;
        e.deg  = deg;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            cmp(e.tag, "sel",   {1'b0, sel_mux_o},       {1'b0, e.sel});
            cmp(e.tag, "fault", faulty_o,                e.flt);
            cmp(e.tag, "perf",  perf_event_o,            e.perf);
            cmp(e.tag, "busy",  {3'b000, reconfig_busy_o}, {3'b000, e.busy});
            cmp(e.tag, "deg",   {3'b000, degraded_o},    {3'b000, e.deg});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input logic [3:0] en, input logic [3:0] err, input logic idle);
        enable_i       = en;
        err_detected_i = err;
        pipe_idle_i    = idle;
    endtask

    // Queue an expectation, advance n clocks, then compare.
    task automatic step_exp(input int n, input string tag, input logic [2:0] sel,
                            input logic [3:0] flt, input logic [3:0] perf,
                            input logic busy, input logic deg);
        push_exp(tag, sel, flt, perf, busy, deg);
        tick(n);
        check_sb();
    endtask

    task automatic do_clear(input string tag);
        clear_i = 1'b1;
        drv(4'hF, 4'h0, 1'b1);
        step_exp(1, tag, 3'b111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        clear_i = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        clear_i = 1'b0;
        drv(4'h0, 4'h0, 1'b1);
        #12;
        push_exp("reset", 3'b111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        check_sb();
        rst_n = 1'b1;

        // Clean enabled traffic leaves everything untouched.
        drv(4'hF, 4'h0, 1'b1);
        step_exp(10, "clean10", 3'b111, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Replica 1 reaches 101, flags the next cycle, swaps the cycle after.
        drv(4'hF, 4'b0010, 1'b1);
        step_exp(100, "r1_cnt100", 3'b111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        step_exp(1, "r1_cnt101", 3'b111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drv(4'hF, 4'h0, 1'b1);
        step_exp(1, "r1_flag", 3'b111, 4'b0010, 4'b0010, 1'b0, 1'b0);
        step_exp(1, "r1_swap", 3'b101, 4'b0010, 4'b0000, 1'b0, 1'b0);
        step_exp(3, "r1_nopulse", 3'b101, 4'b0010, 4'b0000, 1'b0, 1'b0);

        // Replica 0 alternating error/clean never accumulates.
        for (int c = 0; c < 200; c++) begin
            drv(4'hF, (c % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1);
            step_exp(1, "r0_alt", 3'b101, 4'b0010, 4'b0000, 1'b0, 1'b0);
        end

        do_clear("clear1");

        // Replica 2 faults while the pipe is busy: swap waits for idle.
        drv(4'hF, 4'b0100, 1'b0);
        tick(101);
        drv(4'hF, 4'h0, 1'b0);
        step_exp(1, "r2_flag", 3'b111, 4'b0100, 4'b0100, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step_exp(1, "r2_pend", 3'b111, 4'b0100, 4'b0000, 1'b1, 1'b0);
        end
        drv(4'hF, 4'h0, 1'b1);
        step_exp(1, "r2_swap", 3'b011, 4'b0100, 4'b0000, 1'b0, 1'b0);

        do_clear("clear2");

        // Replicas 0 and 2 cross together: lowest swapped, then degraded.
        drv(4'hF, 4'b0101, 1'b1);
        tick(101);
        drv(4'hF, 4'h0, 1'b1);
        step_exp(1, "dual_flag", 3'b111, 4'b0101, 4'b0101, 1'b0, 1'b0);
        step_exp(1, "dual_swap", 3'b110, 4'b0101, 4'b0000, 1'b0, 1'b1);
        step_exp(2, "dual_hold", 3'b110, 4'b0101, 4'b0000, 1'b0, 1'b1);

        do_clear("clear3");

        // Second fault during a pending swap: degrade together with the swap.
        drv(4'hF, 4'b0001, 1'b0);
        tick(3);
        drv(4'hF, 4'b0011, 1'b0);
        tick(98);
        drv(4'hF, 4'b0010, 1'b0);
        step_exp(1, "pend_flag0", 3'b111, 4'b0001, 4'b0001, 1'b0, 1'b0);
        step_exp(1, "pend_busy", 3'b111, 4'b0001, 4'b0000, 1'b1, 1'b0);
        tick(1);
        drv(4'hF, 4'h0, 1'b0);
        step_exp(1, "pend_flag1", 3'b111, 4'b0011, 4'b0010, 1'b1, 1'b0);
        step_exp(1, "pend_wait", 3'b111, 4'b0011, 4'b0000, 1'b1, 1'b0);
        drv(4'hF, 4'h0, 1'b1);
        step_exp(1, "pend_deg", 3'b110, 4'b0011, 4'b0000, 1'b0, 1'b1);

        do_clear("clear4");

        // Spare fault while SPARED degrades without touching the muxes.
        drv(4'hF, 4'b0010, 1'b1);
        tick(101);
        drv(4'hF, 4'h0, 1'b1);
        step_exp(2, "sp_swap", 3'b101, 4'b0010, 4'b0000, 1'b0, 1'b0);
        drv(4'hF, 4'b1000, 1'b1);
        step_exp(101, "sp_cnt101", 3'b101, 4'b0010, 4'b0000, 1'b0, 1'b0);
        drv(4'hF, 4'h0, 1'b1);
        step_exp(1, "sp_flag", 3'b101, 4'b1010, 4'b1000, 1'b0, 1'b0);
        step_exp(1, "sp_deg", 3'b101, 4'b1010, 4'b0000, 1'b0, 1'b1);

        do_clear("clear5");

        // Async reset in the middle of a pending swap.
        drv(4'hF, 4'b0001, 1'b0);
        tick(101);
        drv(4'hF, 4'h0, 1'b0);
        step_exp(2, "rst_pend", 3'b111, 4'b0001, 4'b0000, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("rst_async", 3'b111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        check_sb();
        #1;
        rst_n = 1'b1;
        drv(4'hF, 4'h0, 1'b1);
        step_exp(2, "rst_after", 3'b111, 4'b0000, 4'b0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
